// File: rtl/board_link_if.sv
// board_link_if: game-side flags and serial lines of one board_link instance
interface board_link_if;
  logic       ready1;
  logic       hit1;
  logic [7:0] ship_cords_out;
  logic       tx;
  logic       rx;
  logic       ready2;
  logic       hit2;
  logic [7:0] ship_cords_in;
  logic       tx_busy;
  logic       frame_err;
  modport master (
    output ready1, hit1, ship_cords_out, rx,
    input  tx, ready2, hit2, ship_cords_in, tx_busy, frame_err
  );
  modport slave (
    input  ready1, hit1, ship_cords_out, rx,
    output tx, ready2, hit2, ship_cords_in, tx_busy, frame_err
  );
endinterface

// File: rtl/board_link.sv
// board_link: full-duplex serial exchange of {ready,hit,cords} words with even parity
module board_link #(
  parameter int CLK_DIV = 564
) (
  input logic        clk,
  input logic        rst,
  board_link_if.slave bus
);
  localparam logic [0:0]  TX_IDLE   = 1'b0;
  localparam logic [0:0]  TX_SEND   = 1'b1;
  localparam logic [2:0]  RX_IDLE   = 3'd0;
  localparam logic [2:0]  RX_START  = 3'd1;
  localparam logic [2:0]  RX_DATA   = 3'd2;
  localparam logic [2:0]  RX_PARITY = 3'd3;
  localparam logic [2:0]  RX_STOP   = 3'd4;
  localparam logic [2:0]  RX_BREAK  = 3'd5;
  localparam logic [11:0] BIT_END   = 12'(CLK_DIV - 1);
  localparam logic [11:0] HALF_END  = 12'(CLK_DIV / 2 - 1);

  logic [0:0]  tx_state;
  logic [9:0]  last_sent;
  logic [9:0]  tx_word;
  logic [12:0] tx_sh;
  logic [11:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic        tx_r;

  assign tx_word     = {bus.ready1, bus.hit1, bus.ship_cords_out};
  assign bus.tx      = tx_r;
  assign bus.tx_busy = tx_state == TX_SEND;

  // tx_sh holds the whole frame; tx_r is loaded from the bit about to be shifted in
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      last_sent <= '0;
      tx_sh     <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_r      <= 1'b1;
    end else if (tx_state == TX_IDLE) begin
      tx_r <= 1'b1;
      if (tx_word != last_sent) begin
        last_sent <= tx_word;
        tx_sh     <= {1'b1, ^tx_word, tx_word, 1'b0};
        tx_r      <= 1'b0;
        tx_cnt    <= '0;
        tx_bit    <= '0;
        tx_state  <= TX_SEND;
      end
    end else if (tx_cnt == BIT_END) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd12) begin
        tx_state <= TX_IDLE;
        tx_r     <= 1'b1;
      end else begin
        tx_bit <= tx_bit + 4'd1;
        tx_r   <= tx_sh[1];
        tx_sh  <= tx_sh >> 1;
      end
    end else begin
      tx_cnt <= tx_cnt + 12'd1;
    end
  end

  logic        s0;
  logic        s1;
  logic [2:0]  rx_state;
  logic [11:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [9:0]  rx_data;
  logic        rx_par;
  logic        tick;
  logic        ready2_r;
  logic        hit2_r;
  logic [7:0]  cords_r;
  logic        err_r;

  assign tick              = rx_cnt == BIT_END;
  assign bus.ready2        = ready2_r;
  assign bus.hit2          = hit2_r;
  assign bus.ship_cords_in = cords_r;
  assign bus.frame_err     = err_r;

  // sample points sit mid-bit: half a period after the start edge, then whole periods
  always_ff @(posedge clk) begin
    if (rst) begin
      s0       <= 1'b1;
      s1       <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_par   <= 1'b0;
      ready2_r <= 1'b0;
      hit2_r   <= 1'b0;
      cords_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      s0    <= bus.rx;
      s1    <= s0;
      err_r <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!s1) rx_state <= RX_START;
        end
        RX_START: begin
          rx_cnt <= rx_cnt == HALF_END ? 12'd0 : rx_cnt + 12'd1;
          if (rx_cnt == HALF_END) begin
            rx_bit   <= '0;
            rx_state <= s1 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_cnt <= tick ? 12'd0 : rx_cnt + 12'd1;
          if (tick) begin
            rx_data <= {s1, rx_data[9:1]};
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit == 4'd9) rx_state <= RX_PARITY;
          end
        end
        RX_PARITY: begin
          rx_cnt <= tick ? 12'd0 : rx_cnt + 12'd1;
          if (tick) begin
            rx_par   <= s1;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_cnt <= tick ? 12'd0 : rx_cnt + 12'd1;
          if (tick) begin
            if (s1 && rx_par == ^rx_data) begin
              ready2_r <= rx_data[9];
              hit2_r   <= rx_data[8];
              cords_r  <= rx_data[7:0];
              rx_state <= RX_IDLE;
            end else begin
              err_r    <= 1'b1;
              rx_state <= s1 ? RX_IDLE : RX_BREAK;
            end
          end
        end
        RX_BREAK: if (s1) rx_state <= RX_IDLE;
        default:  rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_link.sv
// tb_board_link: directed loopback and injected-frame checks of board_link at CLK_DIV=8
module tb_board_link;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop = 1'b1;
  logic rx_drv = 1'b1;
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int rises = 0;
  int err_cnt = 0;
  logic prev_busy = 1'b0;
  logic seen02 = 1'b0;

  board_link_if bus();
  board_link #(.CLK_DIV(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.rx = loop ? bus.tx : rx_drv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic r, input logic h, input logic [7:0] c);
    check(tag, 32'({bus.ready2, bus.hit2, bus.ship_cords_in}), 32'({r, h, c}));
  endtask

  task automatic clr();
    busy_cnt = 0;
    rises = 0;
    err_cnt = 0;
    seen02 = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      busy_cnt += int'(bus.tx_busy);
      rises += int'(bus.tx_busy && !prev_busy);
      prev_busy = bus.tx_busy;
      err_cnt += int'(bus.frame_err);
      seen02 |= bus.ship_cords_in == 8'h02;
    end
  endtask

  task automatic set_in(input logic r, input logic h, input logic [7:0] c);
    bus.ready1 = r;
    bus.hit1 = h;
    bus.ship_cords_out = c;
  endtask

  task automatic send(input logic [9:0] d, input logic par_ok, input logic stop);
    rx_drv = 1'b0;
    run(8);
    for (int i = 0; i < 10; i++) begin
      rx_drv = d[i];
      run(8);
    end
    rx_drv = (^d) ^ !par_ok;
    run(8);
    rx_drv = stop;
    run(8);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 8'h00);
    run(3);
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_busy", 32'(bus.tx_busy), 32'd0);
    check("reset_err", 32'(bus.frame_err), 32'd0);
    outs("reset_outs", 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    run(1);
    check("post_reset_busy", 32'(bus.tx_busy), 32'd0);
    clr();
    run(20);
    check("post_reset_silent", 32'(busy_cnt), 32'd0);

    clr();
    set_in(1'b1, 1'b1, 8'h37);
    run(1);
    check("f37_start", 32'(bus.tx), 32'd0);
    run(119);
    check("f37_len", 32'(busy_cnt), 32'd104);
    check("f37_frames", 32'(rises), 32'd1);
    check("f37_err", 32'(err_cnt), 32'd0);
    outs("f37_outs", 1'b1, 1'b1, 8'h37);

    clr();
    set_in(1'b1, 1'b1, 8'h01);
    run(30);
    set_in(1'b1, 1'b1, 8'h02);
    run(30);
    set_in(1'b1, 1'b1, 8'h03);
    run(250);
    check("latest_frames", 32'(rises), 32'd2);
    check("latest_len", 32'(busy_cnt), 32'd208);
    check("latest_no02", 32'(seen02), 32'd0);
    check("latest_err", 32'(err_cnt), 32'd0);
    outs("latest_outs", 1'b1, 1'b1, 8'h03);

    loop = 1'b0;
    rx_drv = 1'b1;
    run(5);
    clr();
    send(10'h155, 1'b0, 1'b1);
    run(4);
    check("par_err_pulse", 32'(err_cnt), 32'd1);
    outs("par_err_outs", 1'b1, 1'b1, 8'h03);
    clr();
    send(10'h155, 1'b1, 1'b1);
    run(4);
    check("good155_err", 32'(err_cnt), 32'd0);
    outs("good155_outs", 1'b0, 1'b1, 8'h55);

    clr();
    send(10'h3C3, 1'b1, 1'b0);
    check("stop_err_pulse", 32'(err_cnt), 32'd1);
    outs("stop_err_outs", 1'b0, 1'b1, 8'h55);
    clr();
    run(50);
    check("break_quiet", 32'(err_cnt), 32'd0);
    outs("break_outs", 1'b0, 1'b1, 8'h55);
    rx_drv = 1'b1;
    run(10);
    clr();
    send(10'h2AA, 1'b1, 1'b1);
    run(4);
    check("after_break_err", 32'(err_cnt), 32'd0);
    outs("after_break_outs", 1'b1, 1'b0, 8'hAA);

    clr();
    rx_drv = 1'b0;
    run(2);
    rx_drv = 1'b1;
    run(30);
    check("glitch_err", 32'(err_cnt), 32'd0);
    outs("glitch_outs", 1'b1, 1'b0, 8'hAA);
    clr();
    send(10'h0F0, 1'b1, 1'b1);
    run(4);
    check("after_glitch_err", 32'(err_cnt), 32'd0);
    outs("after_glitch_outs", 1'b0, 1'b0, 8'hF0);

    loop = 1'b1;
    clr();
    set_in(1'b0, 1'b0, 8'h99);
    run(44);
    check("midframe_busy", 32'(bus.tx_busy), 32'd1);
    rst = 1'b1;
    run(1);
    check("midrst_tx", 32'(bus.tx), 32'd1);
    check("midrst_busy", 32'(bus.tx_busy), 32'd0);
    check("midrst_err", 32'(bus.frame_err), 32'd0);
    outs("midrst_outs", 1'b0, 1'b0, 8'h00);
    set_in(1'b0, 1'b0, 8'h00);
    run(1);
    rst = 1'b0;
    run(1);
    check("rst_release_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_release_tx", 32'(bus.tx), 32'd1);
    clr();
    run(20);
    check("rst_release_silent", 32'(busy_cnt), 32'd0);
    clr();
    set_in(1'b0, 1'b1, 8'h5A);
    run(1);
    check("f5a_start", 32'(bus.tx), 32'd0);
    run(119);
    check("f5a_len", 32'(busy_cnt), 32'd104);
    check("f5a_err", 32'(err_cnt), 32'd0);
    outs("f5a_outs", 1'b0, 1'b1, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_link.md
BOARD_LINK -- requirements
Module: board_link

Interface
REQ-001 Parameter: CLK_DIV, default 564, clock cycles per serial bit period; legal range 4..4095.
REQ-002 Port: clk  input  1  system clock; all logic on posedge clk.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: ready1  input  1  local ready flag from the game FSM.
REQ-005 Port: hit1  input  1  local hit flag from the game FSM.
REQ-006 Port: ship_cords_out  input  8  local shot/answer coordinates from the game FSM.
REQ-007 Port: tx  output  1  serial line to the peer board; idle high.
REQ-008 Port: rx  input  1  serial line from the peer board; asynchronous, idle high.
REQ-009 Port: ready2  output  1  peer ready flag, last valid frame.
REQ-010 Port: hit2  output  1  peer hit flag, last valid frame.
REQ-011 Port: ship_cords_in  output  8  peer coordinates, last valid frame.
REQ-012 Port: tx_busy  output  1  high while a frame is being transmitted.
REQ-013 Port: frame_err  output  1  one-cycle pulse on a rejected received frame.

Function
REQ-014 Payload word D[9:0] = {ready, hit, cords[7:0]}; D[9]=ready, D[8]=hit, D[7:0]=cords.
REQ-015 Frame = 13 bits, each exactly CLK_DIV cycles: start (0), D[0]..D[9] LSB first, parity = XOR of D[9:0] (even parity), stop (1).
REQ-016 TX holds register last_sent[9:0], reset 0; TX FSM states: TX_IDLE, TX_SEND.
REQ-017 In TX_IDLE, when {ready1,hit1,ship_cords_out} != last_sent: capture word into shift register and last_sent, enter TX_SEND; tx goes low on the next clock edge.
REQ-018 Input changes during TX_SEND do not alter the frame in flight; on return to TX_IDLE the current input is compared again, so only the latest value is sent, with no idle gap beyond 1 cycle.
REQ-019 A value that changes and reverts during one frame is not re-sent (compared against last_sent only).
REQ-020 tx_busy = 1 in TX_SEND, 0 in TX_IDLE; tx is registered, driven 1 in TX_IDLE.
REQ-021 RX synchronises rx through 2 flip-flops (reset value 1); all RX decisions use the synchronised value.
REQ-022 RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK.
REQ-023 RX_IDLE -> RX_START on synchronised rx = 0; RX_START waits CLK_DIV/2 (integer) cycles, then rx=0 -> RX_DATA, rx=1 -> RX_IDLE (glitch, no error).
REQ-024 RX_DATA samples 10 bits, each CLK_DIV cycles after the previous sample point, LSB first; RX_PARITY samples parity; RX_STOP samples stop bit.
REQ-025 At stop sample, if stop=1 and parity matches XOR of received data: ready2/hit2/ship_cords_in update on the next edge, all three simultaneously; return to RX_IDLE.
REQ-026 Parity mismatch or stop=0: frame_err high exactly 1 cycle, outputs unchanged; stop=0 -> RX_BREAK, which waits for rx=1 before RX_IDLE; parity-only error -> RX_IDLE.
REQ-027 TX and RX operate independently; full-duplex traffic is supported.
REQ-028 Baud and bit counters are wide enough for CLK_DIV=4095 and 13 bits; no wrap-around inside a frame.

Reset
REQ-029 rst, including mid-frame, forces: tx=1, tx_busy=0, frame_err=0, ready2=0, hit2=0, ship_cords_in=8'h00, last_sent=0, both FSMs idle, sync FFs=1.
REQ-030 The first cycle after rst deassertion, with inputs all 0, transmits nothing.

Verification (CLK_DIV=8, tx looped to rx unless stated)
REQ-031 Set {ready1,hit1,cords}={1,1,8'h37} -> tx low 1 cycle later; frame lasts 104 cycles; ready2=1, hit2=1, ship_cords_in=8'h37 after stop sample; frame_err never asserted.
REQ-032 Change cords 8'h01 -> 8'h02 -> 8'h03 during one frame -> exactly one extra frame carrying 8'h03; 8'h02 never seen at outputs.
REQ-033 Drive rx externally with correct bits but flipped parity, payload 10'h155 -> frame_err 1-cycle pulse, outputs keep previous values.
REQ-034 Drive rx externally with stop bit 0 then hold low 50 cycles -> frame_err pulse, no further frame or error until rx returns high, then next valid frame received normally.
REQ-035 rx low pulse of 2 cycles -> no state change, no frame_err.
REQ-036 Assert rst at bit 5 of a TX frame -> tx=1 next cycle, tx_busy=0, receiver outputs 0; subsequent input change transmits a full frame.
